// File: rtl/sdram_arbit.sv
// sdram_arbit: holds the bus for init, then grants refresh > write > read one at a time
// and muxes the current owner's command/address/bank/data onto the SDRAM pins.
`default_nettype none

module sdram_arbit #(
  parameter int ADDR_W        = 13,
  parameter int BA_W          = 2,
  parameter int DATA_W        = 16,
  parameter int GRANT_TIMEOUT = 1023
) (
  input  logic              sysclk_100M,
  input  logic              rst_n,
  input  logic [3:0]        init_cmd,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [BA_W-1:0]   init_ba,
  input  logic              init_end,
  input  logic              arbit_refresh_req,
  input  logic [3:0]        refresh_cmd,
  input  logic              refresh_end,
  output logic              arbit_refresh_ack,
  input  logic              wr_req,
  input  logic              rd_req,
  output logic              wr_ack,
  output logic              rd_ack,
  input  logic              wr_end,
  input  logic              rd_end,
  input  logic [3:0]        wr_cmd,
  input  logic [3:0]        rd_cmd,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [BA_W-1:0]   wr_ba,
  input  logic [BA_W-1:0]   rd_ba,
  input  logic [DATA_W-1:0] wr_dq,
  input  logic              wr_dq_en,
  output logic [3:0]        sdram_cmd,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [BA_W-1:0]   sdram_ba,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
  output logic              err_timeout
);

  localparam int              CNT_W    = $clog2(GRANT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(GRANT_TIMEOUT - 1);
  localparam logic [3:0]       CMD_NOP  = 4'b0111;
  // Auto-refresh needs A10 high (all banks); every other address bit is zero.
  localparam logic [ADDR_W-1:0] REF_ADDR = ADDR_W'(11'h400);

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_ARBIT   = 3'd1,
    S_REFRESH = 3'd2,
    S_WRITE   = 3'd3,
    S_READ    = 3'd4
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wdog;
  logic             granted;
  logic             owner_end;
  logic             timeout_hit;

  assign granted = (state == S_REFRESH) || (state == S_WRITE) || (state == S_READ);

  always_comb begin
    owner_end = 1'b0;
    case (state)
      S_REFRESH: owner_end = refresh_end;
      S_WRITE:   owner_end = wr_end;
      S_READ:    owner_end = rd_end;
      default:   owner_end = 1'b0;
    endcase
  end

  // A completion arriving on the last allowed cycle releases normally, without an error.
  assign timeout_hit = granted && !owner_end && (wdog == TMO_LAST);

  always_comb begin
    state_next = state;
    case (state)
      S_INIT: begin
        if (init_end) state_next = S_ARBIT;
      end
      S_ARBIT: begin
        if (arbit_refresh_req) state_next = S_REFRESH;
        else if (wr_req)       state_next = S_WRITE;
        else if (rd_req)       state_next = S_READ;
      end
      S_REFRESH, S_WRITE, S_READ: begin
        if (owner_end || timeout_hit) state_next = S_ARBIT;
      end
      default: state_next = S_INIT;
    endcase
  end

  always_ff @(posedge sysclk_100M or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_INIT;
      wdog        <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      wdog        <= granted ? wdog + 1'b1 : '0;
      err_timeout <= timeout_hit;
    end
  end

  assign arbit_refresh_ack = (state == S_REFRESH);
  assign wr_ack            = (state == S_WRITE);
  assign rd_ack            = (state == S_READ);

  always_comb begin
    sdram_cmd  = CMD_NOP;
    sdram_addr = '0;
    sdram_ba   = '0;
    case (state)
      S_INIT: begin
        sdram_cmd  = init_cmd;
        sdram_addr = init_addr;
        sdram_ba   = init_ba;
      end
      S_REFRESH: begin
        sdram_cmd  = refresh_cmd;
        sdram_addr = REF_ADDR;
      end
      S_WRITE: begin
        sdram_cmd  = wr_cmd;
        sdram_addr = wr_addr;
        sdram_ba   = wr_ba;
      end
      S_READ: begin
        sdram_cmd  = rd_cmd;
        sdram_addr = rd_addr;
        sdram_ba   = rd_ba;
      end
      default: begin
        sdram_cmd  = CMD_NOP;
        sdram_addr = '0;
        sdram_ba   = '0;
      end
    endcase
  end

  assign sdram_dq_oe  = (state == S_WRITE) && wr_dq_en;
  assign sdram_dq_out = sdram_dq_oe ? wr_dq : '0;

endmodule

`default_nettype wire

// File: tb/tb_sdram_arbit.sv
// Directed self-checking bench for sdram_arbit (short watchdog so timeouts are reachable).
`default_nettype none

module tb_sdram_arbit;

  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int DATA_W = 16;
  localparam int GT     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [3:0]        init_cmd;
  logic [ADDR_W-1:0] init_addr;
  logic [BA_W-1:0]   init_ba;
  logic              init_end;
  logic              arbit_refresh_req;
  logic [3:0]        refresh_cmd;
  logic              refresh_end;
  logic              arbit_refresh_ack;
  logic              wr_req, rd_req, wr_ack, rd_ack, wr_end, rd_end;
  logic [3:0]        wr_cmd, rd_cmd;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [BA_W-1:0]   wr_ba, rd_ba;
  logic [DATA_W-1:0] wr_dq;
  logic              wr_dq_en;
  logic [3:0]        sdram_cmd;
  logic [ADDR_W-1:0] sdram_addr;
  logic [BA_W-1:0]   sdram_ba;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;
  logic              err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sdram_arbit #(
    .ADDR_W(ADDR_W), .BA_W(BA_W), .DATA_W(DATA_W), .GRANT_TIMEOUT(GT)
  ) dut (
    .sysclk_100M(clk), .rst_n(rst_n),
    .init_cmd(init_cmd), .init_addr(init_addr), .init_ba(init_ba), .init_end(init_end),
    .arbit_refresh_req(arbit_refresh_req), .refresh_cmd(refresh_cmd),
    .refresh_end(refresh_end), .arbit_refresh_ack(arbit_refresh_ack),
    .wr_req(wr_req), .rd_req(rd_req), .wr_ack(wr_ack), .rd_ack(rd_ack),
    .wr_end(wr_end), .rd_end(rd_end), .wr_cmd(wr_cmd), .rd_cmd(rd_cmd),
    .wr_addr(wr_addr), .rd_addr(rd_addr), .wr_ba(wr_ba), .rd_ba(rd_ba),
    .wr_dq(wr_dq), .wr_dq_en(wr_dq_en),
    .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe), .err_timeout(err_timeout)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // acks packed as {refresh, wr, rd}
  function automatic logic [31:0] acks();
    return {29'd0, arbit_refresh_ack, wr_ack, rd_ack};
  endfunction

  initial begin
    rst_n = 1'b0;
    init_cmd = 4'b0010; init_addr = 13'h155; init_ba = 2'd1; init_end = 1'b0;
    arbit_refresh_req = 1'b0; refresh_cmd = 4'b0001; refresh_end = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_end = 1'b0; rd_end = 1'b0;
    wr_cmd = 4'b0100; rd_cmd = 4'b0101;
    wr_addr = 13'h123; rd_addr = 13'h0ab; wr_ba = 2'd2; rd_ba = 2'd3;
    wr_dq = 16'hA5A5; wr_dq_en = 1'b0;

    // Reset state
    cyc(); cyc();
    chk("rst_acks", acks(), 32'd0);
    chk("rst_err", err_timeout, 1'b0);
    chk("rst_oe", sdram_dq_oe, 1'b0);
    chk("rst_cmd", sdram_cmd, 4'b0010);
    chk("rst_addr", sdram_addr, 13'h155);
    rst_n = 1'b1;

    // INIT tracks init bus until init_end
    for (int i = 0; i < 17; i++) cyc();
    init_cmd = 4'b0011; init_addr = 13'h1fff; init_ba = 2'd3;
    #1;
    chk("init_cmd", sdram_cmd, 4'b0011);
    chk("init_addr", sdram_addr, 13'h1fff);
    chk("init_ba", sdram_ba, 2'd3);
    init_end = 1'b1;
    cyc();
    chk("arbit_cmd", sdram_cmd, 4'b0111);
    chk("arbit_addr", sdram_addr, 13'h0);
    chk("arbit_ba", sdram_ba, 2'd0);
    chk("arbit_acks", acks(), 32'd0);

    // Refresh grant
    arbit_refresh_req = 1'b1;
    cyc();
    chk("ref_acks", acks(), 32'b100);
    chk("ref_cmd", sdram_cmd, 4'b0001);
    chk("ref_addr", sdram_addr, 13'h400);
    chk("ref_ba", sdram_ba, 2'd0);
    arbit_refresh_req = 1'b0;
    cyc();
    chk("ref_hold", acks(), 32'b100);
    refresh_end = 1'b1;
    cyc();
    refresh_end = 1'b0;
    chk("ref_release", acks(), 32'd0);
    chk("ref_rel_cmd", sdram_cmd, 4'b0111);

    // Simultaneous requests: refresh, then write, then read
    arbit_refresh_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    cyc();
    chk("prio_ref", acks(), 32'b100);
    arbit_refresh_req = 1'b0; refresh_end = 1'b1;
    cyc();
    refresh_end = 1'b0;
    chk("prio_gap", acks(), 32'd0);
    cyc();
    chk("prio_wr", acks(), 32'b010);
    chk("wr_cmd", sdram_cmd, 4'b0100);
    chk("wr_addr", sdram_addr, 13'h123);
    chk("wr_ba", sdram_ba, 2'd2);
    chk("wr_oe_off", sdram_dq_oe, 1'b0);
    chk("wr_dq_off", sdram_dq_out, 16'h0);
    wr_dq_en = 1'b1;
    #1;
    chk("wr_oe_on", sdram_dq_oe, 1'b1);
    chk("wr_dq_on", sdram_dq_out, 16'hA5A5);
    rd_end = 1'b1;
    cyc();
    rd_end = 1'b0;
    chk("wr_ignore_rd_end", acks(), 32'b010);
    wr_req = 1'b0;
    cyc();
    chk("wr_req_drop", acks(), 32'b010);
    wr_end = 1'b1; wr_dq_en = 1'b0;
    cyc();
    wr_end = 1'b0;
    chk("wr_release", acks(), 32'd0);
    chk("wr_rel_oe", sdram_dq_oe, 1'b0);
    cyc();
    chk("prio_rd", acks(), 32'b001);
    chk("rd_cmd", sdram_cmd, 4'b0101);
    chk("rd_addr", sdram_addr, 13'h0ab);
    rd_req = 1'b0; rd_end = 1'b1;
    cyc();
    rd_end = 1'b0;
    chk("rd_release", acks(), 32'd0);

    // Watchdog forced release after GT granted cycles
    wr_req = 1'b1;
    cyc();
    wr_req = 1'b0;
    chk("tmo_grant", acks(), 32'b010);
    for (int i = 0; i < GT - 1; i++) cyc();
    chk("tmo_last_ack", acks(), 32'b010);
    chk("tmo_last_err", err_timeout, 1'b0);
    cyc();
    chk("tmo_err", err_timeout, 1'b1);
    chk("tmo_acks", acks(), 32'd0);
    chk("tmo_cmd", sdram_cmd, 4'b0111);
    cyc();
    chk("tmo_err_pulse", err_timeout, 1'b0);

    // End on the last allowed cycle wins over the watchdog
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    chk("tie_grant", acks(), 32'b001);
    for (int i = 0; i < GT - 1; i++) cyc();
    rd_end = 1'b1;
    cyc();
    rd_end = 1'b0;
    chk("tie_acks", acks(), 32'd0);
    chk("tie_err", err_timeout, 1'b0);

    // Asynchronous reset in the middle of a write grant
    wr_req = 1'b1; wr_dq_en = 1'b1;
    cyc();
    chk("arst_pre_oe", sdram_dq_oe, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_acks", acks(), 32'd0);
    chk("arst_oe", sdram_dq_oe, 1'b0);
    chk("arst_cmd", sdram_cmd, 4'b0011);
    chk("arst_err", err_timeout, 1'b0);
    cyc();
    chk("arst_hold", acks(), 32'd0);
    rst_n = 1'b1;
    wr_req = 1'b0; wr_dq_en = 1'b0;
    cyc();
    chk("arst_to_arbit", sdram_cmd, 4'b0111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
